// File: rtl/up_counter_ctrl_pkg.sv
// Shared definitions for the modulo-N up counter: FSM state encodings and
// counting-mode constants.
package up_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } upcnt_state_t;

    localparam int MODE_WRAP    = 0;
    localparam int MODE_ONESHOT = 1;

endpackage : up_counter_ctrl_pkg

// File: rtl/upcnt_fsm.sv
// Control FSM for the up counter. It tracks IDLE/COUNT/DONE and tells the
// datapath whether to increment or clear q. When neither is requested, q holds.
// It also produces the next value of the terminal-count pulse.
// In free-run mode the FSM never leaves COUNT, and start has no effect.
module upcnt_fsm
    import up_counter_ctrl_pkg::*;
#(
    parameter int ONE_SHOT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         en_i,
    input  logic         at_max_i,
    input  logic         load_i,
    output upcnt_state_t state_o,
    output logic         inc_o,
    output logic         clr_o,
    output logic         tc_next_o
);

    localparam bit           ONESHOT  = (ONE_SHOT == MODE_ONESHOT);
    localparam upcnt_state_t ST_RESET = ONESHOT ? ST_IDLE : ST_COUNT;

    upcnt_state_t state_q;
    upcnt_state_t state_d;

    // State register; reset lands in IDLE for one-shot and in COUNT for free-run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls. A load freezes the FSM and suppresses tc.
    always_comb begin
        state_d   = state_q;
        inc_o     = 1'b0;
        clr_o     = 1'b0;
        tc_next_o = 1'b0;
        if (!load_i) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i && ONESHOT) begin
                        clr_o   = 1'b1;
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (en_i) begin
                        if (!at_max_i) begin
                            inc_o = 1'b1;
                        end else begin
                            tc_next_o = 1'b1;
                            if (ONESHOT) begin
                                state_d = ST_DONE;
                            end else begin
                                clr_o = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule : upcnt_fsm

// File: rtl/up_counter_ctrl.sv
// Modulo-N up counter with load, enable and start control and a registered
// terminal-count pulse. It supports free-run (wrap) mode and one-shot mode.
// Optional feature macro: UPCNT_OVF_STICKY_EN. When it is defined, a sticky
// overflow flag reports a second terminal count that arrives before ovf_clr.
module up_counter_ctrl
    import up_counter_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int ONE_SHOT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             at_max;
    logic             fsm_inc;
    logic             fsm_clr;
    logic             fsm_tc_next;
    upcnt_state_t     fsm_state;

    // The comparison uses >= so that any out-of-range value still wraps or stops.
    // Such a value cannot occur, because loads are clamped.
    assign at_max = (q_q >= MAX_Q);

    upcnt_fsm #(
        .ONE_SHOT (ONE_SHOT)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start),
        .en_i      (en),
        .at_max_i  (at_max),
        .load_i    (load),
        .state_o   (fsm_state),
        .inc_o     (fsm_inc),
        .clr_o     (fsm_clr),
        .tc_next_o (fsm_tc_next)
    );

    // Count datapath: a clamped load wins over the FSM's clear/increment.
    // Otherwise q holds.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (fsm_clr) begin
            q_d = '0;
        end else if (fsm_inc) begin
            q_d = q_q + ONE_Q;
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= fsm_tc_next;
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = (fsm_state == ST_COUNT);

`ifdef UPCNT_OVF_STICKY_EN
    logic seen_q;
    logic seen_d;
    logic ovf_q;
    logic ovf_d;

    // The first terminal count after a clear only marks it as seen.
    // A second terminal count before the clear raises ovf. The clear wins.
    always_comb begin
        seen_d = seen_q;
        ovf_d  = ovf_q;
        if (ovf_clr) begin
            seen_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (fsm_tc_next) begin
            if (seen_q) begin
                ovf_d = 1'b1;
            end else begin
                seen_d = 1'b1;
            end
        end
    end

    // Sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule : up_counter_ctrl
